// File: rtl/bird_pkg.sv
// Shared types and screen geometry for the bird physics block.
package bird_pkg;

  localparam int Y_W      = 10;
  localparam int V_W      = 8;
  localparam int P_W      = 12;
  localparam int SCREEN_H = 480;
  localparam int BIRD_H   = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FLYING = 2'd1,
    ST_DEAD   = 2'd2
  } bird_state_t;

  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/flap_debounce.sv
// Flap button conditioning: 2-FF synchroniser, stability down-counter and
// a single-cycle pulse on each accepted rising level.
module flap_debounce
  import bird_pkg::*;
#(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flap,
  output logic flap_edge
);

  localparam int CNT_W = cnt_width(DEB_CYCLES);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DEB_CYCLES - 1);

  logic [1:0]       sync;
  logic             lvl;
  logic [CNT_W-1:0] cnt;

  // Any sample matching the accepted level restarts the stability window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync      <= 2'b00;
      lvl       <= 1'b0;
      cnt       <= RELOAD;
      flap_edge <= 1'b0;
    end else begin
      sync      <= {sync[0], flap};
      flap_edge <= 1'b0;
      if (sync[1] == lvl) begin
        cnt <= RELOAD;
      end else if (cnt == '0) begin
        lvl       <= sync[1];
        cnt       <= RELOAD;
        flap_edge <= sync[1];
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/bird_physics.sv
// Bird flight physics: pending-flap flag, per-frame physics FSM and post-crash hold timer.
// Build option: define BIRD_CEIL_BOUNCE_EN to make the ceiling a bounce instead of a crash.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | parked at Y_START, waiting for a flap to launch
//   ST_FLYING | gravity/flap physics applied on every frame_tick
//   ST_DEAD   | crashed, y frozen; flaps ignored until the hold expires
module bird_physics
  import bird_pkg::*;
#(
  parameter int Y_START    = 240,
  parameter int Y_MAX      = SCREEN_H - BIRD_H,
  parameter int GRAVITY    = 1,
  parameter int FLAP_VEL   = 8,
  parameter int VMAX       = 10,
  parameter int DEB_CYCLES = 1_000_000,
  parameter int DEAD_HOLD  = 60
) (
  input  logic           clk,
  input  logic           clr_n,
  input  logic           flap,
  input  logic           frame_tick,
  output logic [Y_W-1:0] y,
  output logic           alive,
  output logic           crash,
  output logic [1:0]     state
);

`ifdef BIRD_CEIL_BOUNCE_EN
  localparam bit CEIL_BOUNCE = 1'b1;
`else
  localparam bit CEIL_BOUNCE = 1'b0;
`endif

  localparam int HOLD_W = cnt_width(DEAD_HOLD + 1);

  localparam logic signed [V_W-1:0] VEL_FLAP  = V_W'(-FLAP_VEL);
  localparam logic signed [V_W:0]   VEL_GRAV9 = (V_W+1)'(GRAVITY);
  localparam logic signed [V_W:0]   VEL_MAX9  = (V_W+1)'(VMAX);
  localparam logic signed [P_W-1:0] NY_MAX    = P_W'(Y_MAX);
  localparam logic [Y_W-1:0]        Y_IDLE    = Y_W'(Y_START);
  localparam logic [Y_W-1:0]        Y_LAUNCH  = Y_W'(Y_START - FLAP_VEL);
  localparam logic [Y_W-1:0]        Y_FLOOR   = Y_W'(Y_MAX);
  localparam logic [HOLD_W-1:0]     HOLD_LOAD = HOLD_W'(DEAD_HOLD);

  logic [1:0] rst_sync;
  logic       rst_n;

  // Assert immediately with clr_n, release two clocks later.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  logic flap_edge;

  flap_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_flap_debounce (
    .clk       (clk),
    .rst_n     (rst_n),
    .flap      (flap),
    .flap_edge (flap_edge)
  );

  bird_state_t              st;
  logic signed [V_W-1:0]    vel;
  logic [HOLD_W-1:0]        hold_cnt;
  logic                     pending;
  logic                     hold_open;

  assign hold_open = (hold_cnt == '0);

  // An edge coincident with a tick survives the tick's clear and applies next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
    end else if (st == ST_DEAD && !hold_open) begin
      pending <= 1'b0;
    end else if (frame_tick) begin
      pending <= flap_edge;
    end else if (flap_edge) begin
      pending <= 1'b1;
    end
  end

  logic signed [V_W:0]   vel_inc;
  logic signed [V_W-1:0] vel_new;
  logic signed [P_W-1:0] ny;
  logic                  floor_hit;
  logic                  ceil_hit;
  logic                  crash_now;

  always_comb begin
    vel_inc = {vel[V_W-1], vel} + VEL_GRAV9;
    if (pending)                  vel_new = VEL_FLAP;
    else if (vel_inc > VEL_MAX9)  vel_new = VEL_MAX9[V_W-1:0];
    else                          vel_new = vel_inc[V_W-1:0];
    ny = $signed({{(P_W-Y_W){1'b0}}, y}) + $signed({{(P_W-V_W){vel_new[V_W-1]}}, vel_new});
    floor_hit = (ny >= NY_MAX);
    ceil_hit  = ny[P_W-1];
    crash_now = floor_hit || (ceil_hit && !CEIL_BOUNCE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= ST_IDLE;
      y        <= Y_IDLE;
      vel      <= '0;
      alive    <= 1'b0;
      crash    <= 1'b0;
      hold_cnt <= '0;
    end else begin
      crash <= 1'b0;
      if (frame_tick) begin
        case (st)
          ST_IDLE: begin
            if (pending) begin
              st    <= ST_FLYING;
              vel   <= VEL_FLAP;
              y     <= Y_LAUNCH;
              alive <= 1'b1;
            end
          end
          ST_FLYING: begin
            if (crash_now) begin
              st       <= ST_DEAD;
              y        <= floor_hit ? Y_FLOOR : '0;
              vel      <= '0;
              alive    <= 1'b0;
              crash    <= 1'b1;
              hold_cnt <= HOLD_LOAD;
            end else if (ceil_hit) begin
              y   <= '0;
              vel <= '0;
            end else begin
              y   <= ny[Y_W-1:0];
              vel <= vel_new;
            end
          end
          ST_DEAD: begin
            vel <= '0;
            if (!hold_open) begin
              hold_cnt <= hold_cnt - 1'b1;
            end else if (pending) begin
              st <= ST_IDLE;
              y  <= Y_IDLE;
            end
          end
          default: begin
            st    <= ST_IDLE;
            y     <= Y_IDLE;
            vel   <= '0;
            alive <= 1'b0;
          end
        endcase
      end
    end
  end

  assign state = st;

endmodule

// File: tb/tb_bird_physics.sv
// Self-checking bench for bird_physics against a frame-level flight model.
module tb_bird_physics;

  localparam int DEB  = 4;
  localparam int HOLD = 3;
`ifdef BIRD_CEIL_BOUNCE_EN
  localparam bit BOUNCE = 1'b1;
`else
  localparam bit BOUNCE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic       flap = 1'b0;
  logic       frame_tick = 1'b0;
  logic [9:0] y;
  logic       alive;
  logic       crash;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  bird_physics #(.DEB_CYCLES(DEB), .DEAD_HOLD(HOLD)) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .flap       (flap),
    .frame_tick (frame_tick),
    .y          (y),
    .alive      (alive),
    .crash      (crash),
    .state      (state)
  );

  always #5 clk = ~clk;

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // Frame-level model: 0=idle, 1=flying, 2=dead.
  int m_st, m_y, m_vel, m_hold;
  bit m_pend, m_crash;

  task automatic model_reset();
    m_st = 0; m_y = 240; m_vel = 0; m_hold = 0; m_pend = 0; m_crash = 0;
  endtask

  task automatic model_flap();
    if (!(m_st == 2 && m_hold < HOLD)) m_pend = 1;
  endtask

  task automatic model_tick();
    bit p;
    int nv, ny;
    p = m_pend;
    m_pend = 0;
    m_crash = 0;
    case (m_st)
      0: if (p) begin m_st = 1; m_vel = -8; m_y = 232; end
      1: begin
        nv = p ? -8 : ((m_vel + 1 > 10) ? 10 : m_vel + 1);
        ny = m_y + nv;
        if (ny >= 464) begin
          m_y = 464; m_vel = 0; m_st = 2; m_crash = 1; m_hold = 0;
        end else if (ny < 0) begin
          m_y = 0; m_vel = 0;
          if (!BOUNCE) begin m_st = 2; m_crash = 1; m_hold = 0; end
        end else begin
          m_y = ny; m_vel = nv;
        end
      end
      default: begin
        if (m_hold >= HOLD) begin
          if (p) begin m_st = 0; m_y = 240; m_vel = 0; end
        end else begin
          m_hold++;
        end
      end
    endcase
  endtask

  function automatic logic [13:0] exp_vec();
    return {m_y[9:0], m_st[1:0], (m_st == 1), m_crash};
  endfunction

  function automatic string fmt(input logic [13:0] v);
    return $sformatf("y=%0d st=%0d alive=%0b crash=%0b", v[13:4], v[3:2], v[1], v[0]);
  endfunction

  task automatic do_reset();
    flap = 0; frame_tick = 0;
    @(negedge clk); clr_n = 0;
    repeat (3) @(negedge clk);
    clr_n = 1;
    repeat (5) @(negedge clk);
    model_reset();
  endtask

  task automatic press();
    flap = 1;
    repeat (12) @(negedge clk);
    flap = 0;
    repeat (12) @(negedge clk);
    model_flap();
  endtask

  task automatic do_tick();
    @(negedge clk); frame_tick = 1;
    @(negedge clk); frame_tick = 0;
    model_tick();
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({y, state, alive, crash} !== exp_vec() || exp_vec() !== {10'd240, 2'd0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset_idle step %0d: got %s want %s", i, fmt({y, state, alive, crash}), fmt(exp_vec()));
      end
      do_tick();
    end
  endtask

  task automatic test_launch();
    int exp_y[4] = '{232, 225, 219, 214};
    press();
    for (int i = 0; i < 4; i++) begin
      do_tick();
      checks++;
      if ({y, state, alive, crash} !== exp_vec() || y !== exp_y[i] || state !== 2'd1) begin
        errors++;
        $display("FAIL launch tick %0d: got %s want %s (y %0d)", i, fmt({y, state, alive, crash}), fmt(exp_vec()), exp_y[i]);
      end
    end
  endtask

  task automatic test_free_fall();
    int p1, p2;
    bit died = 0;
    p1 = y; p2 = y;
    for (int i = 0; i < 80 && !died; i++) begin
      p2 = p1; p1 = y;
      do_tick();
      checks++;
      if ({y, state, alive, crash} !== exp_vec()) begin
        errors++;
        $display("FAIL free_fall tick %0d: got %s want %s", i, fmt({y, state, alive, crash}), fmt(exp_vec()));
      end
      if (m_st == 2) died = 1;
    end
    checks++;
    if (!died || (p1 - p2) != 10) begin
      errors++;
      $display("FAIL free_fall_clamp: died=%0b last step %0d want 10", died, p1 - p2);
    end
    @(negedge clk);
    checks++;
    if (crash !== 1'b0 || state !== 2'd2 || y !== 10'd464) begin
      errors++;
      $display("FAIL crash_width: crash=%0b st=%0d y=%0d want crash=0 st=2 y=464", crash, state, y);
    end
  endtask

  task automatic test_dead_hold();
    press();
    do_tick();
    press();
    do_tick();
    do_tick();
    checks++;
    if ({y, state, alive, crash} !== exp_vec() || state !== 2'd2) begin
      errors++;
      $display("FAIL dead_ignore: got %s want %s", fmt({y, state, alive, crash}), fmt(exp_vec()));
    end
    // Time the press so the accepted edge coincides with the tick cycle.
    @(negedge clk); flap = 1;
    repeat (6) @(negedge clk);
    frame_tick = 1;
    @(negedge clk); frame_tick = 0;
    model_tick();
    model_flap();
    checks++;
    if ({y, state, alive, crash} !== exp_vec() || state !== 2'd2) begin
      errors++;
      $display("FAIL edge_on_tick: got %s want %s", fmt({y, state, alive, crash}), fmt(exp_vec()));
    end
    repeat (6) @(negedge clk);
    flap = 0;
    repeat (12) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      do_tick();
      checks++;
      if ({y, state, alive, crash} !== exp_vec() || state !== 2'd0 || y !== 10'd240) begin
        errors++;
        $display("FAIL respawn tick %0d: got %s want %s", i, fmt({y, state, alive, crash}), fmt(exp_vec()));
      end
    end
  endtask

  task automatic test_bouncy();
    for (int i = 0; i < 10; i++) begin
      flap = ~flap;
      repeat (2) @(negedge clk);
    end
    flap = 1;
    repeat (12) @(negedge clk);
    model_flap();
    for (int i = 0; i < 51; i++) begin
      do_tick();
      checks++;
      if ({y, state, alive, crash} !== exp_vec()) begin
        errors++;
        $display("FAIL bouncy_hold tick %0d: got %s want %s", i, fmt({y, state, alive, crash}), fmt(exp_vec()));
      end
    end
    flap = 0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_ceiling();
    int prev_y;
    bit hit = 0;
    do_reset();
    press();
    do_tick();
    for (int i = 0; i < 8; i++) do_tick();
    checks++;
    if ({y, state, alive, crash} !== exp_vec() || y !== 10'd204) begin
      errors++;
      $display("FAIL ceiling_setup: got %s want %s", fmt({y, state, alive, crash}), fmt(exp_vec()));
    end
    for (int i = 0; i < 30 && !hit; i++) begin
      prev_y = y;
      press();
      do_tick();
      checks++;
      if ({y, state, alive, crash} !== exp_vec()) begin
        errors++;
        $display("FAIL ceiling tick %0d: got %s want %s", i, fmt({y, state, alive, crash}), fmt(exp_vec()));
      end
      if (m_y == 0) hit = 1;
    end
    checks++;
    if (!hit || prev_y != 4 || y !== 10'd0 || alive !== BOUNCE || state !== (BOUNCE ? 2'd1 : 2'd2)) begin
      errors++;
      $display("FAIL ceiling_hit: hit=%0b prev_y=%0d y=%0d alive=%0b st=%0d want prev_y=4 y=0 alive=%0b",
               hit, prev_y, y, alive, state, BOUNCE);
    end
    press();
    do_tick();
    checks++;
    if ({y, state, alive, crash} !== exp_vec()) begin
      errors++;
      $display("FAIL ceiling_after: got %s want %s", fmt({y, state, alive, crash}), fmt(exp_vec()));
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    press();
    do_tick();
    do_tick();
    @(negedge clk); clr_n = 0;
    #1;
    model_reset();
    checks++;
    if ({y, state, alive, crash} !== {10'd240, 2'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: got %s want %s", fmt({y, state, alive, crash}), fmt(exp_vec()));
    end
    repeat (3) @(negedge clk);
    clr_n = 1;
    repeat (5) @(negedge clk);
    do_tick();
    checks++;
    if ({y, state, alive, crash} !== exp_vec()) begin
      errors++;
      $display("FAIL post_reset: got %s want %s", fmt({y, state, alive, crash}), fmt(exp_vec()));
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 2) == 0) press();
      repeat ($urandom_range(1, 5)) @(negedge clk);
      do_tick();
      checks++;
      if ({y, state, alive, crash} !== exp_vec()) begin
        errors++;
        $display("FAIL random tick %0d: got %s want %s", i, fmt({y, state, alive, crash}), fmt(exp_vec()));
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_launch();
    test_free_fall();
    test_dead_hold();
    test_bouncy();
    test_ceiling();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
